// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: DIGIT bits per clock through one shared adder slice, LSB digit first.
// Optional SERIAL_ADDSUB_SAT_EN: saturate sum[WIDTH-1:0] to the signed limit on overflow.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_addsub: WIDTH must be at least 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_SAT_EN
  logic             msb_q, msb_d;
`endif

  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   ovf_now;
  logic [WIDTH-1:0]       final_res;

  // Shared digit slice; overflow is carry-into-MSB xor carry-out, recovered from the top digit bit.
  always_comb begin
    dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    res_cat   = {dsum[DIGIT-1:0], res_q};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
    ovf_now   = dsum[DIGIT] ^ (a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_now) final_res = msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else         final_res = res_shift;
`else
    final_res = res_shift;
`endif
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
    msb_d   = msb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SERIAL_ADDSUB_SAT_EN
          msb_d   = A[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          sum_d   = {dsum[DIGIT], final_res};
          ovf_d   = ovf_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
      msb_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDSUB_SAT_EN
      msb_q   <= msb_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised digit-serial add/subtract unit, the next generation of the 8-bit serial adder. Operands are captured on `start`, then processed DIGIT bits per clock, LSB digit first, through one shared DIGIT-bit adder slice. It adds a subtract mode, busy/done handshake, signed-overflow flag and selectable digit width. The block sits in the arithmetic datapath wherever area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration-time check, `$error` if not).

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous reset, active-low
start  input  1  request; sampled only while busy=0
sub  input  1  0 = A+B, 1 = A-B; captured with the operands
A  input  WIDTH  operand A; captured when start is accepted
B  input  WIDTH  operand B; captured when start is accepted
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH+1  result; sum[WIDTH] = carry-out (for sub: 1 = no borrow, i.e. A>=B unsigned)
ovf  output  1  two's-complement overflow of sum[WIDTH-1:0]

Behaviour:
- Reset: one clock, synchronous, active-low. On resetn=0 at a rising edge: FSM to IDLE; busy=0, done=0, sum=0, ovf=0; internal shift registers, digit counter and carry cleared. Reset wins over start in the same cycle.
- FSM has two states, IDLE and RUN. Let N = WIDTH/DIGIT.
- IDLE -> RUN: at edge E0 with start=1 and busy=0.
  - Latch A into the A shift register.
  - Latch B into the B shift register, inverted if sub=1.
  - Carry register loads sub (1 for subtract).
  - Counter loads 0; busy goes 1.
- RUN: at each edge E1..EN, add the low DIGIT bits of both shift registers plus the carry.
  - Shift the result digit into the result register from the top.
  - Shift both operand registers right by DIGIT.
  - Update the carry; increment the counter.
- Completion at edge EN (counter = N-1):
  - sum = {carry_out, result}.
  - ovf = carry into MSB XOR carry out of MSB.
  - done=1 for exactly the cycle after EN; busy=0 from EN. FSM returns to IDLE.
- Latency: N clocks from the start-sample edge to the result edge. DIGIT=1 takes WIDTH cycles; DIGIT=WIDTH takes 1 cycle.
- sum and ovf hold the previous result during RUN. They change only at a completion edge or at reset.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is accepted, so back-to-back throughput is one result per N+1 cycles.
- Operand and sub changes while busy are ignored; values are captured only at E0.
- Reset during RUN aborts the operation: no done pulse, and sum/ovf are cleared.
- Arithmetic is modulo 2^WIDTH in sum[WIDTH-1:0]. Subtract is A + ~B + 1.

Optional Feature:
SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf=1, sum[WIDTH-1:0] saturates to the signed limit. If A's MSB was 0, it becomes 0 followed by all ones (max positive); otherwise 1 followed by all zeros (min negative).
- Defined: sum[WIDTH] and ovf are reported unchanged; latency is unchanged.
- Not defined: wrap-around result only; no saturation logic is present.

Test Plan:
- WIDTH=8, DIGIT=1, sub=0, A=0xFF, B=0xA1, start pulse -> busy high 8 cycles; done 1 cycle; sum=0x1A0, ovf=0.
- WIDTH=8, DIGIT=1, sub=1, A=0xFE, B=0x91 -> sum=0x16D (no borrow), ovf=0. Then A=0x10, B=0x20 -> sum=0x0F0, ovf=0.
- WIDTH=8, sub=0, A=0x7F, B=0x01 -> sum=0x080, ovf=1. With SERIAL_ADDSUB_SAT_EN defined -> sum=0x07F, ovf=1.
- WIDTH=8, DIGIT=4, A=0xAF, B=0x71 -> busy exactly 2 cycles; sum=0x120.
- Second start pulse mid-operation with new A/B -> ignored; first result correct. start during the done cycle -> accepted; next done N+1 cycles after the previous one.
- resetn=0 for one cycle at the 4th RUN cycle -> no done; busy=0, sum=0, ovf=0. A fresh start completes normally.
